// File: rtl/mfp_ahb_master_if.sv
// Command/response and AHB-lite bus signals for mfp_ahb_master.
// The master modport is the initiator's view; the slave modport is the requester/bus-side view.
interface mfp_ahb_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        timeout;
  logic [31:0] HADDR;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, timeout,
    output HADDR, HSIZE, HTRANS, HWRITE, HWDATA, HBURST, HPROT, HMASTLOCK,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, timeout,
    input  HADDR, HSIZE, HTRANS, HWRITE, HWDATA, HBURST, HPROT, HMASTLOCK,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/mfp_ahb_master.sv
// AHB-lite initiator: single read/write commands to pipelined AHB-lite transfers.
// Optional wait-state watchdog enabled by defining MFP_AHB_MASTER_TIMEOUT_EN.
module mfp_ahb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              HCLK,
  input  logic              HRESET,
  mfp_ahb_master_if.master  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic [1:0]  r_state;
  logic        r_a_vld;
  logic        r_hwrite;
  logic [31:0] r_haddr;
  logic [2:0]  r_hsize;
  logic [31:0] r_a_wdata;
  logic        r_d_vld;
  logic        r_d_write;
  logic [31:0] r_hwdata;
  logic        r_cancel;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic w_cmd_ready;
  logic w_accept;
  logic w_advance;
  logic w_complete;
  logic w_err_start;
  logic w_a_nxt;
  logic w_d_nxt;

  assign w_cmd_ready = !HRESET && (r_state != S_ERR) && (!r_a_vld || bus.HREADY);
  assign w_accept    = bus.cmd_valid && w_cmd_ready;
  assign w_advance   = r_a_vld && bus.HREADY;
  assign w_complete  = r_d_vld && bus.HREADY;
  assign w_err_start = r_d_vld && bus.HRESP && !bus.HREADY && (r_state != S_ERR);
  assign w_a_nxt     = w_accept || (r_a_vld && !w_advance);
  assign w_d_nxt     = w_advance || (r_d_vld && !w_complete);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= S_IDLE;
      r_a_vld     <= 1'b0;
      r_hwrite    <= 1'b0;
      r_haddr     <= '0;
      r_hsize     <= 3'b010;
      r_a_wdata   <= '0;
      r_d_vld     <= 1'b0;
      r_d_write   <= 1'b0;
      r_hwdata    <= '0;
      r_cancel    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      case (r_state)
        S_IDLE, S_BUSY: begin
          if (w_err_start) begin
            // First error cycle: drop the pending address phase; anything accepted
            // now is owed an error response after the failing transfer.
            r_a_vld  <= 1'b0;
            r_cancel <= r_a_vld || w_accept;
            r_state  <= S_ERR;
          end else begin
            if (w_accept) begin
              r_a_vld   <= 1'b1;
              r_haddr   <= bus.cmd_addr;
              r_hwrite  <= bus.cmd_write;
              r_hsize   <= {1'b0, bus.cmd_size};
              r_a_wdata <= bus.cmd_write ? bus.cmd_wdata : '0;
            end else if (w_advance) begin
              r_a_vld <= 1'b0;
            end
            if (w_advance) begin
              r_d_vld   <= 1'b1;
              r_d_write <= r_hwrite;
              r_hwdata  <= r_hwrite ? r_a_wdata : '0;
            end else if (w_complete) begin
              r_d_vld  <= 1'b0;
              r_hwdata <= '0;
            end
            if (w_complete) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= bus.HRESP;
              r_rsp_rdata <= (r_d_write || bus.HRESP) ? '0 : bus.HRDATA;
            end
            r_state <= (w_a_nxt || w_d_nxt) ? S_BUSY : S_IDLE;
          end
        end
        S_ERR: begin
          if (r_d_vld) begin
            if (bus.HREADY) begin
              r_d_vld     <= 1'b0;
              r_hwdata    <= '0;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              if (!r_cancel) r_state <= S_IDLE;
            end
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_cancel    <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MFP_AHB_MASTER_TIMEOUT_EN
  localparam int unsigned TO_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TO_W     = (TO_W_RAW < 8) ? 8 : ((TO_W_RAW > 32) ? 32 : TO_W_RAW);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (r_d_vld && !bus.HREADY) begin
      if (r_to_cnt != '1) r_to_cnt <= r_to_cnt + 1'b1;
      if (r_to_cnt + 1'b1 == TO_LIM) r_timeout <= 1'b1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign bus.timeout = r_timeout;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign bus.timeout = 1'b0;
`endif

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.HTRANS    = r_a_vld ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR     = r_haddr;
  assign bus.HWRITE    = r_hwrite;
  assign bus.HSIZE     = r_hsize;
  assign bus.HWDATA    = r_hwdata;
  assign bus.HBURST    = 3'b000;
  assign bus.HPROT     = 4'b0011;
  assign bus.HMASTLOCK = 1'b0;

endmodule
